// File: rtl/timer_dev.sv
// timer_dev: programmable 32-bit countdown timer with maskable level interrupt.
// Optional prescaler is built when TIMER_PRESCALE_EN is defined.
// Ports:
//   Clock          system clock, rising edge
//   Reset          asynchronous active-low reset
//   Addr[3:2]      word select: 0 CTRL, 1 PRESET, 2 COUNT, 3 PSC
//   WE             write strobe for the selected register
//   DIn[31:0]      write data
//   DOut[31:0]     combinational read data of the selected register
//   IRQ            interrupt request, irq_pend & IM
module timer_dev (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:2]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  localparam int unsigned DATA_W = 32;
`ifdef TIMER_PRESCALE_EN
  localparam int unsigned PSC_W  = 8;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t              state_q, state_d;
  logic                enable_q, enable_d;
  logic [1:0]          mode_q, mode_d;
  logic                im_q, im_d;
  logic [DATA_W-1:0]   preset_q, preset_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic                irq_pend_q, irq_pend_d;
  logic                irq_set, irq_clr_fsm, bus_clr, step_ok;
`ifdef TIMER_PRESCALE_EN
  logic [PSC_W-1:0]    psc_q, psc_d;
  logic [PSC_W-1:0]    tick_q, tick_d;
`endif

  // State and register file
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      enable_q   <= 1'b0;
      mode_q     <= 2'b00;
      im_q       <= 1'b0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_pend_q <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      psc_q      <= '0;
      tick_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_pend_q <= irq_pend_d;
`ifdef TIMER_PRESCALE_EN
      psc_q      <= psc_d;
      tick_q     <= tick_d;
`endif
    end
  end

  // Next-state: FSM first, then bus writes override CTRL/PRESET/PSC
  always_comb begin
    state_d     = state_q;
    enable_d    = enable_q;
    mode_d      = mode_q;
    im_d        = im_q;
    preset_d    = preset_q;
    count_d     = count_q;
    irq_set     = 1'b0;
    irq_clr_fsm = 1'b0;
    bus_clr     = 1'b0;
`ifdef TIMER_PRESCALE_EN
    psc_d       = psc_q;
    tick_d      = tick_q;
    step_ok     = (tick_q == psc_q);
`else
    step_ok     = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        if (enable_q) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
`ifdef TIMER_PRESCALE_EN
        tick_d  = '0;
`endif
      end
      CNT: begin
        if (!enable_q) begin
          state_d = IDLE;
        end else if (step_ok) begin
`ifdef TIMER_PRESCALE_EN
          tick_d = '0;
`endif
          // COUNT of 0 or 1 both terminate; the counter never wraps
          if (count_q > DATA_W'(1)) begin
            count_d = count_q - DATA_W'(1);
          end else begin
            count_d = '0;
            state_d = INT;
            irq_set = 1'b1;
          end
        end else begin
`ifdef TIMER_PRESCALE_EN
          tick_d = tick_q + PSC_W'(1);
`endif
        end
      end
      INT: begin
        if (mode_q == 2'b01) begin
          irq_clr_fsm = 1'b1;
          state_d     = enable_q ? LOAD : IDLE;
        end else begin
          enable_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (WE) begin
      case (Addr)
        2'd0: begin
          enable_d = DIn[0];
          mode_d   = DIn[2:1];
          im_d     = DIn[3];
          bus_clr  = 1'b1;
        end
        2'd1: begin
          preset_d = DIn;
          bus_clr  = 1'b1;
        end
`ifdef TIMER_PRESCALE_EN
        2'd3: psc_d = DIn[PSC_W-1:0];
`endif
        default: ;
      endcase
    end

    // Bus clear beats an FSM set on the same edge
    if (bus_clr)          irq_pend_d = 1'b0;
    else if (irq_set)     irq_pend_d = 1'b1;
    else if (irq_clr_fsm) irq_pend_d = 1'b0;
    else                  irq_pend_d = irq_pend_q;
  end

  // Read mux
  always_comb begin
    DOut = '0;
    case (Addr)
      2'd0: DOut = {28'b0, im_q, mode_q, enable_q};
      2'd1: DOut = preset_q;
      2'd2: DOut = count_q;
`ifdef TIMER_PRESCALE_EN
      2'd3: DOut = DATA_W'(psc_q);
`endif
      default: DOut = '0;
    endcase
  end

  assign IRQ = irq_pend_q & im_q;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scoreboard bench for timer_dev. Stimulus pushes the edge at
// which IRQ must rise; a negedge monitor pops and compares on each IRQ rise.
module tb_timer_dev;

  logic        Clock;
  logic        Reset;
  logic [3:2]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  timer_dev dut (
    .Clock (Clock),
    .Reset (Reset),
    .Addr  (Addr),
    .WE    (WE),
    .DIn   (DIn),
    .DOut  (DOut),
    .IRQ   (IRQ)
  );

  typedef struct {
    int at;     // rising edge index after which IRQ is first high
    bit pulse;  // IRQ must be low again one cycle later
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  logic irq_prev = 1'b0;
  bit   chk_fall = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every IRQ rise against the scoreboard
  always @(negedge Clock) begin
    if (chk_fall) begin
      check("irq_pulse_width", 32'(IRQ), 32'd0);
      chk_fall = 1'b0;
    end
    if (IRQ && !irq_prev) begin
      if (exp_q.size() == 0) begin
        check("irq_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("irq_edge", 32'(cyc), 32'(e.at));
        if (Addr == 2'd2) check("count_at_irq", DOut, 32'd0);
        chk_fall = e.pulse;
      end
    end
    irq_prev = IRQ;
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_edge(input int e);
    if (cyc > e) check("wait_edge_overrun", 32'(cyc), 32'(e));
    while (cyc < e) step();
  endtask

  // Write lands at the next rising edge; k returns that edge index
  task automatic wr(input logic [1:0] a, input logic [31:0] d, output int k);
    Addr = a;
    DIn  = d;
    WE   = 1'b1;
    step();
    k    = cyc;
    WE   = 1'b0;
    Addr = 2'd2;
  endtask

  task automatic wr_at(input int e, input logic [1:0] a, input logic [31:0] d);
    int k;
    wait_edge(e - 1);
    wr(a, d, k);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = a;
    #1;
    v    = DOut;
    Addr = 2'd2;
  endtask

  task automatic push(input int at, input bit pulse);
    exp_t e;
    e.at    = at;
    e.pulse = pulse;
    exp_q.push_back(e);
  endtask

  initial begin
    logic [31:0] v;
    int k, kk, n, m, e, last;
    bit im, auto_md;
    logic [1:0] mode;

    Reset = 1'b0;
    Addr  = 2'd2;
    WE    = 1'b0;
    DIn   = '0;
    repeat (2) step();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check("reset_dout", v, 32'd0);
    end
    check("reset_irq", 32'(IRQ), 32'd0);
    Reset = 1'b1;
    repeat (2) step();

    // Reset mid-count
    wr(2'd1, 32'd20, kk);
    wr(2'd0, 32'h9, k);
    wait_edge(k + 15);
    rd(2'd2, v);
    check("midcount_count", v, 32'd7);
    #1 Reset = 1'b0;
    #1;
    check("midcount_irq", 32'(IRQ), 32'd0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check("midcount_dout", v, 32'd0);
    end
    step();
    Reset = 1'b1;
    repeat (10) step();
    rd(2'd0, v);
    check("after_reset_ctrl", v, 32'd0);
    rd(2'd2, v);
    check("after_reset_count", v, 32'd0);

    // Directed one-shot, PRESET=5
    wr(2'd1, 32'd5, kk);
    wr(2'd0, 32'h9, k);
    push(k + 7, 1'b0);
    wait_edge(k + 2);
    rd(2'd2, v);
    check("oneshot_count_load", v, 32'd5);
    wait_edge(k + 7);
    rd(2'd2, v);
    check("oneshot_count_zero", v, 32'd0);
    wait_edge(k + 10);
    check("oneshot_irq_held", 32'(IRQ), 32'd1);
    rd(2'd0, v);
    check("oneshot_ctrl", v, 32'h8);
    wr(2'd0, 32'h8, kk);
    check("oneshot_irq_cleared", 32'(IRQ), 32'd0);

    // Directed auto-reload, PRESET=3
    wr(2'd1, 32'd3, kk);
    wr(2'd0, 32'hB, k);
    for (int j = 0; j < 3; j++) push(k + 5 + 5 * j, 1'b1);
    wr_at(k + 17, 2'd0, 32'hA);
    wait_edge(k + 20);
    rd(2'd2, v);
    check("auto_frozen_a", v, 32'd3);
    wait_edge(k + 25);
    rd(2'd2, v);
    check("auto_frozen_b", v, 32'd3);
    wr(2'd0, 32'h0, kk);

    // Mask
    wr(2'd1, 32'd2, kk);
    wr(2'd0, 32'h1, k);
    wait_edge(k + 6);
    check("mask_irq", 32'(IRQ), 32'd0);
    rd(2'd0, v);
    check("mask_ctrl", v, 32'd0);
    wr(2'd0, 32'h8, kk);
    step();
    check("mask_im_irq", 32'(IRQ), 32'd0);
    wr(2'd0, 32'h0, kk);

    // PRESET=0 and PRESET=1 terminate on the same edge
    for (int p = 0; p < 2; p++) begin
      wr(2'd1, 32'(p), kk);
      wr(2'd0, 32'h9, k);
      push(k + 3, 1'b0);
      wait_edge(k + 5);
      wr(2'd0, 32'h0, kk);
    end

    // PRESET and COUNT writes during CNT
    wr(2'd1, 32'd10, kk);
    wr(2'd0, 32'h9, k);
    push(k + 12, 1'b0);
    wr_at(k + 5, 2'd1, 32'd100);
    rd(2'd2, v);
    check("preset_wr_count", v, 32'd7);
    wr_at(k + 6, 2'd2, 32'hDEAD);
    rd(2'd2, v);
    check("count_wr_ignored", v, 32'd6);
    wait_edge(k + 14);
    wr(2'd0, 32'h0, kk);
    rd(2'd1, v);
    check("preset_readback", v, 32'd100);

    // Randomized runs against the scoreboard
    for (int it = 0; it < 10; it++) begin
      n       = int'($urandom_range(0, 12));
      m       = (n < 1) ? 1 : n;
      im      = 1'($urandom_range(0, 1));
      auto_md = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0:       mode = 2'b00;
        1:       mode = 2'b10;
        default: mode = 2'b11;
      endcase
      if (auto_md) mode = 2'b01;
      wr(2'd1, 32'(n), kk);
      wr(2'd0, {28'b0, im, mode, 1'b1}, k);
      e = k + 2 + m;
      if (!auto_md) begin
        if (im) push(e, 1'b0);
        wait_edge(e + 3);
        rd(2'd0, v);
        check("rand_ctrl", v, {28'b0, im, mode, 1'b0});
        rd(2'd2, v);
        check("rand_count", v, 32'd0);
        check("rand_irq", 32'(IRQ), 32'(im));
      end else begin
        if (im) for (int j = 0; j < 3; j++) push(e + j * (m + 2), 1'b1);
        last = e + 2 * (m + 2);
        wr_at(last + 2, 2'd0, {28'b0, im, mode, 1'b0});
        wait_edge(last + m + 7);
        rd(2'd2, v);
        check("rand_frozen", v, 32'(n));
      end
      wr(2'd0, 32'h0, kk);
      step();
      check("rand_cleared", 32'(IRQ), 32'd0);
    end

`ifdef TIMER_PRESCALE_EN
    wr(2'd3, 32'd3, kk);
    rd(2'd3, v);
    check("psc_readback", v, 32'd3);
    wr(2'd1, 32'd2, kk);
    wr(2'd0, 32'h9, k);
    push(k + 10, 1'b0);
    wait_edge(k + 6);
    rd(2'd2, v);
    check("psc_first_step", v, 32'd1);
    wait_edge(k + 12);
    check("psc_irq", 32'(IRQ), 32'd1);
    wr(2'd0, 32'h0, kk);
    wr(2'd3, 32'd0, kk);
`else
    wr(2'd3, 32'hFF, kk);
    rd(2'd3, v);
    check("psc_absent", v, 32'd0);
`endif

    repeat (5) step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer_dev.md
# timer_dev

Programmable 32-bit countdown timer on the system bridge; its `IRQ` output drives one `HWInt` line of the coprocessor-0 interrupt logic. Software programs it with bus writes (control, preset) and reads back control, preset and live count. It supports one-shot and auto-reload modes. A maskable level interrupt is raised when the count reaches zero.

## Interface
- No parameters; register map is fixed.
- `Clock`  in  1  system clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Addr`  in  [3:2]  register word select: 0 CTRL, 1 PRESET, 2 COUNT, 3 PSC.
- `WE`  in  1  bus write strobe for selected register, sampled at rising edge.
- `DIn`  in  32  bus write data.
- `DOut`  out  32  combinational read data of selected register.
- `IRQ`  out  1  interrupt request to the CP0 `HWInt` bit; `IRQ = irq_pend & IM`.

## Operation
- CTRL fields: [0] `Enable`, [2:1] `Mode` (00 one-shot, 01 auto-reload, 10/11 behave as 00 and read back as written), [3] `IM`. Bits [31:4] are read as 0 and ignored on write.
- PRESET: 32-bit reload value, read/write.
- COUNT: 32-bit live counter, read-only; writes to it are ignored.
- Read mux `DOut`:
  - CTRL returns `{28'b0, IM, Mode, Enable}`.
  - PSC returns 0 unless the option under Configuration is enabled.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: stays while `Enable=0`. `Enable=1` moves to LOAD.
  - LOAD: `COUNT <= PRESET`, then CNT.
  - CNT with `Enable=0`: moves to IDLE; COUNT holds its value.
  - CNT with COUNT > 1: COUNT decrements.
  - CNT with COUNT == 1: `COUNT <= 0`, move to INT, set `irq_pend`.
  - CNT with COUNT == 0 (PRESET was 0): move to INT, set `irq_pend`. This behaves the same as PRESET=1.
  - INT, one-shot: `Enable <= 0`, move to IDLE. `irq_pend` stays set.
  - INT, auto-reload: move to LOAD and clear `irq_pend`. The result is a one-cycle pulse. If `Enable=0` (written that cycle), move to IDLE instead.
- `irq_pend` is cleared by any bus write to CTRL or PRESET, and by reset.
- Bus write in the same cycle as an FSM update:
  - The software value wins for CTRL.
  - The FSM acts on the new CTRL from the next edge.
  - A write that clears `irq_pend` takes priority over a set in the same edge.
- PRESET write during CNT does not disturb the running count. It takes effect at the next LOAD.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, PSC=0, `irq_pend`=0, state IDLE. This gives `IRQ`=0 and `DOut`=0 for every address.
- Register writes land at the rising edge where `WE=1`. `DOut` shows the new value in the following cycle.
- One-shot latency: enable written at edge k, PRESET=N≥1.
  - Edge k+1: LOAD.
  - Edge k+2: COUNT=N.
  - Edge k+2+N: COUNT=0, INT, `IRQ` high (if `IM`).
- Auto-reload: `IRQ` pulses for one cycle every N+2 cycles.
- `Reset` asserted mid-count forces all reset values immediately, without waiting for a clock edge. The FSM restarts from IDLE after deassertion.
- COUNT never wraps below 0.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - Adds an 8-bit PSC register at word 3, read/write. `DOut` is zero-extended.
  - Adds an 8-bit tick counter, cleared in LOAD and on each COUNT decrement or INT transition.
  - In CNT, the FSM advances only when the tick counter equals PSC; otherwise the tick counter increments. Each count step therefore takes PSC+1 cycles.
  - PSC=0 behaves the same as the undefined build.
- `TIMER_PRESCALE_EN` undefined:
  - No PSC storage; word 3 reads 0 and ignores writes.
  - COUNT steps every cycle in CNT.

## Test plan
- Reset mid-count: pull `Reset` low while COUNT=7. Required: `DOut`=0 for all addresses and `IRQ`=0 immediately. After release, the block stays IDLE.
- One-shot: PRESET=5, then write CTRL=0x9 at edge k. Required:
  - COUNT reads 5 after k+2 and 0 after k+7.
  - `IRQ` goes high after k+7 and stays high.
  - CTRL reads 0x8.
  - A CTRL write clears `IRQ` at the next edge.
- Auto-reload: PRESET=3, CTRL=0xB. Required: one-cycle `IRQ` pulses spaced 5 cycles apart. Clearing `Enable` stops them with COUNT frozen.
- Mask: CTRL=0x1, PRESET=2. Required: `IRQ` stays 0 at terminal count. Setting `IM` (CTRL=0x8 write) clears `irq_pend`, so `IRQ` stays 0.
- Corner cases:
  - PRESET=0 one-shot reaches INT on the same edge as PRESET=1.
  - A PRESET write to 100 during CNT leaves the current count unchanged.
  - A COUNT write is ignored.
- With `TIMER_PRESCALE_EN`: PSC=3, PRESET=2, one-shot. Required: terminal count 8 cycles after the LOAD→CNT edge. Without the macro, word 3 reads 0 after a write of 0xFF.
